// File: rtl/scu_pkg.sv
// Shared widths, FSM encoding and constants for the SCU partial-sum accumulator.
package scu_pkg;

  localparam int A_BITS    = 12;
  localparam int ACC_BITS  = 20;
  localparam int LANES     = 16;
  localparam int PASS_BITS = 6;
  localparam int NUM_OC    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/scu_round_sat.sv
// One lane of the drain path: rounding arithmetic shift, saturation to A_BITS, optional ReLU.
module scu_round_sat #(
  parameter int A_BITS   = scu_pkg::A_BITS,
  parameter int ACC_BITS = scu_pkg::ACC_BITS
) (
  input  logic signed [ACC_BITS-1:0] i_acc,
  input  logic        [2:0]          i_shift,
  input  logic                       i_relu,
  output logic        [A_BITS-1:0]   o_res
);

  localparam logic signed [ACC_BITS:0] SAT_MAX = (ACC_BITS+1)'((2 ** (A_BITS-1)) - 1);
  localparam logic signed [ACC_BITS:0] SAT_MIN = (ACC_BITS+1)'(-(2 ** (A_BITS-1)));

  logic signed [ACC_BITS:0] w_bias;
  logic signed [ACC_BITS:0] w_sum;
  logic signed [ACC_BITS:0] w_shr;

  // One guard bit keeps the rounding bias from overflowing near full scale.
  always_comb begin
    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    w_bias = '0;
    o_res  = '0;
    if (i_shift != 3'd0) w_bias = (ACC_BITS+1)'(1) << (i_shift - 3'd1);
    w_sum = (ACC_BITS+1)'(i_acc) + w_bias;
    w_shr = w_sum >>> i_shift;
    if (w_shr > SAT_MAX)      o_res = SAT_MAX[A_BITS-1:0];
    else if (w_shr < SAT_MIN) o_res = SAT_MIN[A_BITS-1:0];
    else                      o_res = w_shr[A_BITS-1:0];
    if (i_relu && o_res[A_BITS-1]) o_res = '0;
  end

endmodule

// File: rtl/scu_psum_accumulator.sv
// Accumulates SCU OC0/OC1/OC2 tiles over a programmed pass count, then streams
// rounded/saturated results out one output channel per beat.
module scu_psum_accumulator #(
  parameter int A_BITS    = scu_pkg::A_BITS,
  parameter int ACC_BITS  = scu_pkg::ACC_BITS,
  parameter int LANES     = scu_pkg::LANES,
  parameter int PASS_BITS = scu_pkg::PASS_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [PASS_BITS-1:0]      i_cfg_num_passes,
  input  logic [2:0]                i_cfg_shift,
  input  logic                      i_cfg_relu,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [LANES*A_BITS-1:0]   i_in_oc0,
  input  logic [LANES*A_BITS-1:0]   i_in_oc1,
  input  logic [LANES*A_BITS-1:0]   i_in_oc2,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [1:0]                o_out_oc,
  output logic [LANES*A_BITS-1:0]   o_out_data,
  output logic                      o_busy,
  output logic                      o_done
);

  import scu_pkg::*;

  state_e                     r_state;
  logic [PASS_BITS-1:0]       r_passes;
  logic [PASS_BITS-1:0]       r_pass_cnt;
  logic [2:0]                 r_shift;
  logic                       r_relu;
  logic [1:0]                 r_oc;
  logic                       r_done;
  logic signed [ACC_BITS-1:0] r_acc [NUM_OC][LANES];

  logic [LANES*A_BITS-1:0] w_in [NUM_OC];
  logic [LANES*A_BITS-1:0] w_res;
  logic                    w_in_fire;
  logic                    w_out_fire;

  assign w_in[0]    = i_in_oc0;
  assign w_in[1]    = i_in_oc1;
  assign w_in[2]    = i_in_oc2;
  assign w_in_fire  = (r_state == ACCUM) && i_in_valid;
  assign w_out_fire = (r_state == DRAIN) && i_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_passes   <= '0;
      r_pass_cnt <= '0;
      r_shift    <= '0;
      r_relu     <= 1'b0;
      r_oc       <= '0;
      r_done     <= 1'b0;
      // NOTE: the accumulator array is reset too, so an aborted job never leaks partial sums.
      for (int oc = 0; oc < NUM_OC; oc++)
        for (int ln = 0; ln < LANES; ln++)
          r_acc[oc][ln] <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_passes   <= (i_cfg_num_passes == '0) ? PASS_BITS'(1) : i_cfg_num_passes;
            r_shift    <= i_cfg_shift;
            r_relu     <= i_cfg_relu;
            r_pass_cnt <= '0;
            r_oc       <= '0;
            r_state    <= ACCUM;
            for (int oc = 0; oc < NUM_OC; oc++)
              for (int ln = 0; ln < LANES; ln++)
                r_acc[oc][ln] <= '0;
          end
        end
        ACCUM: begin
          if (w_in_fire) begin
            for (int oc = 0; oc < NUM_OC; oc++)
              for (int ln = 0; ln < LANES; ln++)
                r_acc[oc][ln] <= r_acc[oc][ln] + ACC_BITS'(signed'(w_in[oc][ln*A_BITS +: A_BITS]));
            r_pass_cnt <= r_pass_cnt + PASS_BITS'(1);
            if (r_pass_cnt + PASS_BITS'(1) == r_passes) begin
              r_state <= DRAIN;
              r_oc    <= '0;
            end
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            if (r_oc == 2'(NUM_OC - 1)) begin
              r_oc    <= '0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_oc <= r_oc + 2'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Accumulators are frozen in DRAIN, so the drain result is stable until each handshake.
  for (genvar ln = 0; ln < LANES; ln++) begin : g_lane
    scu_round_sat #(
      .A_BITS   (A_BITS),
      .ACC_BITS (ACC_BITS)
    ) u_round_sat (
      .i_acc   (r_acc[r_oc][ln]),
      .i_shift (r_shift),
      .i_relu  (r_relu),
      .o_res   (w_res[ln*A_BITS +: A_BITS])
    );
  end

  assign o_in_ready  = (r_state == ACCUM);
  assign o_out_valid = (r_state == DRAIN);
  assign o_out_oc    = r_oc;
  assign o_out_data  = o_out_valid ? w_res : '0;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_scu_psum_accumulator.sv
// Directed self-checking bench for scu_psum_accumulator: vector table plus corner sequences.
module tb_scu_psum_accumulator;

  localparam int AB = 12;
  localparam int LN = 16;
  localparam int PB = 6;
  localparam int W  = LN * AB;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [PB-1:0]   cfg_num_passes;
  logic [2:0]      cfg_shift;
  logic            cfg_relu;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_oc0, in_oc1, in_oc2;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_oc;
  logic [W-1:0]    out_data;
  logic            busy;
  logic            done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scu_psum_accumulator dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (start),
    .i_cfg_num_passes (cfg_num_passes),
    .i_cfg_shift      (cfg_shift),
    .i_cfg_relu       (cfg_relu),
    .i_in_valid       (in_valid),
    .o_in_ready       (in_ready),
    .i_in_oc0         (in_oc0),
    .i_in_oc1         (in_oc1),
    .i_in_oc2         (in_oc2),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_out_oc         (out_oc),
    .o_out_data       (out_data),
    .o_busy           (busy),
    .o_done           (done)
  );

  typedef struct {
    int              passes;
    logic [2:0]      shift;
    logic            relu;
    logic signed [AB-1:0] v0, v1, v2;
    logic signed [AB-1:0] e0, e1, e2;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic signed [AB-1:0] v);
    return {LN{v}};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_job(input int passes, input logic [2:0] sh, input logic rl);
    cfg_num_passes = PB'(passes);
    cfg_shift      = sh;
    cfg_relu       = rl;
    start          = 1'b1;
    tick();
    start          = 1'b0;
    check("accum_in_ready", W'(in_ready), W'(1));
    check("accum_busy", W'(busy), W'(1));
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    in_valid = 1'b1;
    in_oc0 = a; in_oc1 = b; in_oc2 = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_beat(input string name, input int oc, input logic [W-1:0] exp);
    out_ready = 1'b1;
    check({name, "_valid"}, W'(out_valid), W'(1));
    check({name, "_oc"}, W'(out_oc), W'(oc));
    check({name, "_data"}, out_data, exp);
    check({name, "_nodone"}, W'(done), W'(0));
    tick();
  endtask

  task automatic finish_checks(input string name);
    check({name, "_done"}, W'(done), W'(1));
    check({name, "_idle"}, W'(busy), W'(0));
    check({name, "_valid_low"}, W'(out_valid), W'(0));
    tick();
    check({name, "_done_pulse"}, W'(done), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] e0, e1, e2, a0, a1, a2, held;

    vecs[0] = '{1, 3'd0, 1'b0,  12'sd5,  -12'sd7, 12'sd2047,  12'sd5,  -12'sd7, 12'sd2047};
    vecs[1] = '{4, 3'd2, 1'b0,  12'sd3,  12'sd5,  -12'sd3,    12'sd3,  12'sd5,  -12'sd3};
    vecs[2] = '{2, 3'd0, 1'b0,  12'sd2047, -12'sd2048, 12'sd1, 12'sd2047, -12'sd2048, 12'sd2};
    vecs[3] = '{2, 3'd0, 1'b1,  -12'sd2048, 12'sd2047, -12'sd1, 12'sd0, 12'sd2047, 12'sd0};
    vecs[4] = '{0, 3'd1, 1'b0,  12'sd3,  -12'sd3, 12'sd1,     12'sd2,  -12'sd1, 12'sd1};
    vecs[5] = '{63, 3'd7, 1'b0, 12'sd2047, -12'sd2048, 12'sd100, 12'sd1008, -12'sd1008, 12'sd49};
    vecs[6] = '{3, 3'd3, 1'b1,  12'sd4,  -12'sd4, 12'sd7,     12'sd2,  12'sd0,  12'sd3};

    rst = 1'b1; start = 1'b0; cfg_num_passes = '0; cfg_shift = '0; cfg_relu = 1'b0;
    in_valid = 1'b0; in_oc0 = '0; in_oc1 = '0; in_oc2 = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_oc", W'(out_oc), W'(0));
    check("rst_out_data", out_data, W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    rst = 1'b0;
    tick();

    // Table-driven jobs with uniform lanes and out_ready held high.
    for (int v = 0; v < 7; v++) begin
      int np;
      np = (vecs[v].passes == 0) ? 1 : vecs[v].passes;
      start_job(vecs[v].passes, vecs[v].shift, vecs[v].relu);
      for (int p = 0; p < np; p++) beat(rep(vecs[v].v0), rep(vecs[v].v1), rep(vecs[v].v2));
      check($sformatf("vec%0d_in_ready_low", v), W'(in_ready), W'(0));
      drain_beat($sformatf("vec%0d_oc0", v), 0, rep(vecs[v].e0));
      drain_beat($sformatf("vec%0d_oc1", v), 1, rep(vecs[v].e1));
      drain_beat($sformatf("vec%0d_oc2", v), 2, rep(vecs[v].e2));
      finish_checks($sformatf("vec%0d", v));
    end

    // Lane-distinct values: 2 passes, shift 0; oc2 saturates for lanes >= 5.
    for (int i = 0; i < LN; i++) begin
      a0[i*AB +: AB] = AB'(i*100 - 800);
      a1[i*AB +: AB] = AB'(i);
      a2[i*AB +: AB] = AB'(1000 + i*5);
      e0[i*AB +: AB] = AB'(2*(i*100 - 800));
      e1[i*AB +: AB] = AB'(2*i);
      e2[i*AB +: AB] = (2000 + i*10 > 2047) ? AB'(2047) : AB'(2000 + i*10);
    end
    start_job(2, 3'd0, 1'b0);
    beat(a0, a1, a2);
    beat(a0, a1, a2);
    drain_beat("lanes_oc0", 0, e0);
    drain_beat("lanes_oc1", 1, e1);
    drain_beat("lanes_oc2", 2, e2);
    finish_checks("lanes");

    // Back-pressure on oc1 for 5 cycles.
    start_job(1, 3'd0, 1'b0);
    beat(rep(12'sd10), rep(12'sd20), rep(12'sd30));
    drain_beat("bp_oc0", 0, rep(12'sd10));
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", W'(out_valid), W'(1));
      check("bp_hold_oc", W'(out_oc), W'(1));
      check("bp_hold_data", out_data, rep(12'sd20));
      check("bp_hold_nodone", W'(done), W'(0));
      tick();
    end
    drain_beat("bp_oc1", 1, rep(12'sd20));
    drain_beat("bp_oc2", 2, rep(12'sd30));
    finish_checks("bp");

    // Stalled input beats with a start pulsed mid-ACCUM carrying different cfg.
    start_job(3, 3'd0, 1'b0);
    beat(rep(12'sd1), rep(-12'sd10), rep(12'sd100));
    in_oc0 = rep(12'sd999); in_oc1 = rep(12'sd999); in_oc2 = rep(12'sd999);
    tick();
    check("stall_in_ready", W'(in_ready), W'(1));
    cfg_num_passes = PB'(1); cfg_shift = 3'd7; cfg_relu = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("stall_start_ignored", W'(in_ready), W'(1));
    beat(rep(12'sd2), rep(-12'sd10), rep(12'sd200));
    check("stall_not_done_early", W'(out_valid), W'(0));
    tick(); tick();
    beat(rep(12'sd3), rep(-12'sd10), rep(12'sd300));
    drain_beat("stall_oc0", 0, rep(12'sd6));
    drain_beat("stall_oc1", 1, rep(-12'sd30));
    drain_beat("stall_oc2", 2, rep(12'sd600));
    finish_checks("stall");

    // Reset while draining oc1 aborts with no done; next job starts clean.
    start_job(1, 3'd0, 1'b0);
    beat(rep(12'sd7), rep(12'sd8), rep(12'sd9));
    drain_beat("rstd_oc0", 0, rep(12'sd7));
    out_ready = 1'b0;
    check("rstd_pre_oc", W'(out_oc), W'(1));
    rst = 1'b1;
    #1;
    check("rstd_valid", W'(out_valid), W'(0));
    check("rstd_busy", W'(busy), W'(0));
    check("rstd_done", W'(done), W'(0));
    check("rstd_oc", W'(out_oc), W'(0));
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rstd_no_done", W'(done), W'(0));
      tick();
    end
    start_job(1, 3'd0, 1'b0);
    beat(rep(12'sd1), rep(12'sd2), rep(12'sd3));
    drain_beat("post_oc0", 0, rep(12'sd1));
    drain_beat("post_oc1", 1, rep(12'sd2));
    drain_beat("post_oc2", 2, rep(12'sd3));
    finish_checks("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
